// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the framebuffer masters and the SDRAM slave.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_sm;
    logic [31:0] dat_ms;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        stb;
    logic        cyc;
    logic        ack;

    modport master (
        input  clk, rst, dat_sm, ack,
        output adr, dat_ms, we, sel, cti, bte, stb, cyc
    );

    modport slave (
        input  clk, rst, adr, dat_ms, we, sel, cti, bte, stb, cyc,
        output dat_sm, ack
    );
endinterface

// File: rtl/fb_reader.sv
// Framebuffer read-back master: bursts raster-order pixels from SDRAM into a
// show-ahead pixel FIFO drained by the video controller.
module fb_reader #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned BURST      = 64,
    parameter int unsigned FIFO_DEPTH = 256
) (
    wshb_if.master                      wshb_ifm,
    input  logic                        pix_rd,
    output logic [23:0]                 pix_data,
    output logic                        pix_sof,
    output logic                        pix_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned PW   = $clog2(NPIX);
    localparam int unsigned BW   = $clog2(BURST) + 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned LW   = AW + 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t         state;
    logic [31:0]    adr;
    logic [PW-1:0]  pix_cnt;
    logic [BW-1:0]  burst_cnt;
    logic           stb;

    logic [24:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [LW-1:0]  level_next;

    logic           push;
    logic           pop;
    logic           last_pix;
    logic           last_beat;
    logic           unused_dat;

    wire clk = wshb_ifm.clk;
    wire rst = wshb_ifm.rst;

    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.stb    = stb;
    assign wshb_ifm.cyc    = stb;
    assign wshb_ifm.dat_ms = '0;
    assign wshb_ifm.we     = 1'b0;
    assign wshb_ifm.sel    = 4'b1111;
    assign wshb_ifm.cti    = 3'd0;
    assign wshb_ifm.bte    = 2'd0;
    assign unused_dat      = ^wshb_ifm.dat_sm[31:24];

    assign push      = (state == REQ) && wshb_ifm.ack;
    assign pop       = pix_rd && !pix_empty;
    assign last_pix  = (pix_cnt == PW'(NPIX - 1));
    assign last_beat = (burst_cnt == BW'(BURST - 1));

    // Burst request FSM; a burst is only admitted when a whole burst fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stb       <= 1'b0;
            adr       <= '0;
            pix_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (level <= LW'(FIFO_DEPTH - BURST)) begin
                        state <= REQ;
                        stb   <= 1'b1;
                    end
                end
                REQ: begin
                    if (wshb_ifm.ack) begin
                        adr       <= adr + 32'd4;
                        pix_cnt   <= pix_cnt + PW'(1);
                        burst_cnt <= burst_cnt + BW'(1);
                        if (last_pix) begin
                            adr     <= '0;
                            pix_cnt <= '0;
                        end
                        if (last_beat || last_pix) begin
                            state     <= IDLE;
                            stb       <= 1'b0;
                            burst_cnt <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    stb   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + LW'(1);
        end else if (pop && !push) begin
            level_next = level - LW'(1);
        end
    end

    // Pixel storage carries the start-of-frame flag alongside the RGB value.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {(pix_cnt == '0), wshb_ifm.dat_sm[23:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pix_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level     <= level_next;
            pix_empty <= (level_next == '0);
        end
    end

    assign fifo_level = level;
    assign pix_data   = mem[rd_ptr][23:0];
    assign pix_sof    = mem[rd_ptr][24] && !pix_empty;
endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: a full-size instance and a tiny-frame instance checked
// against a queue-based model of the fetch order and pixel FIFO.
module tb_fb_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic ack   = 1'b0;
    logic pix_rd = 1'b0;
    logic sel   = 1'b0;

    wshb_if if_a (.clk(clk), .rst(rst_a));
    wshb_if if_b (.clk(clk), .rst(rst_b));

    // Slave returns its own address as data and only acks a live strobe.
    assign if_a.dat_sm = if_a.adr;
    assign if_a.ack    = ack && if_a.stb;
    assign if_b.dat_sm = if_b.adr;
    assign if_b.ack    = ack && if_b.stb;

    logic [23:0] pd_a, pd_b;
    logic        ps_a, ps_b, pe_a, pe_b;
    logic [8:0]  lv_a;
    logic [4:0]  lv_b;

    fb_reader dut_a (
        .wshb_ifm  (if_a.master),
        .pix_rd    (pix_rd),
        .pix_data  (pd_a),
        .pix_sof   (ps_a),
        .pix_empty (pe_a),
        .fifo_level(lv_a)
    );

    fb_reader #(.HDISP(8), .VDISP(4), .BURST(8), .FIFO_DEPTH(16)) dut_b (
        .wshb_ifm  (if_b.master),
        .pix_rd    (pix_rd),
        .pix_data  (pd_b),
        .pix_sof   (ps_b),
        .pix_empty (pe_b),
        .fifo_level(lv_b)
    );

    logic        o_stb, o_cyc, o_sof, o_empty, o_we;
    logic [31:0] o_adr;
    logic [23:0] o_data;
    logic [3:0]  o_sel;
    int          o_level;

    assign o_stb   = sel ? if_b.stb : if_a.stb;
    assign o_cyc   = sel ? if_b.cyc : if_a.cyc;
    assign o_adr   = sel ? if_b.adr : if_a.adr;
    assign o_we    = sel ? if_b.we  : if_a.we;
    assign o_sel   = sel ? if_b.sel : if_a.sel;
    assign o_data  = sel ? pd_b : pd_a;
    assign o_sof   = sel ? ps_b : ps_a;
    assign o_empty = sel ? pe_b : pe_a;
    assign o_level = sel ? 32'(lv_b) : 32'(lv_a);

    int errs   = 0;
    int checks = 0;

    // Reference model: expected FIFO contents plus fetch position in the frame.
    logic [24:0] q[$];
    int idx, bcnt, npix, bsz, depth;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int          pre;
        bit          push, pop, fin, stb_was, exp_stb;
        logic [31:0] a;
        logic [24:0] e;
        pre     = q.size();
        push    = o_stb && ack;
        pop     = pix_rd && (pre > 0);
        stb_was = o_stb;
        fin     = 1'b0;
        e       = '0;
        if (pop) begin
            chk("pix_data", 32'(o_data), 32'(q[0][23:0]));
            chk("pix_sof", 32'(o_sof), 32'(q[0][24]));
        end
        if (push) begin
            a = 32'(idx * 4);
            chk("adr", o_adr, a);
            chk("push_not_full", 32'(o_level < depth), 32'd1);
            e    = {(idx == 0), a[23:0]};
            idx  = (idx + 1) % npix;
            bcnt = bcnt + 1;
            fin  = (bcnt == bsz) || (idx == 0);
            if (fin) bcnt = 0;
        end
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        exp_stb = push ? !fin : (stb_was ? 1'b1 : (pre <= depth - bsz));
        chk("fifo_level", 32'(o_level), 32'(q.size()));
        chk("pix_empty", 32'(o_empty), 32'(q.size() == 0));
        chk("stb", 32'(o_stb), 32'(exp_stb));
        chk("cyc", 32'(o_cyc), 32'(o_stb));
    endtask

    task automatic do_reset(input logic which);
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        ack    = 1'b0;
        pix_rd = 1'b0;
        repeat (2) @(posedge clk);
        sel = which;
        q.delete();
        idx  = 0;
        bcnt = 0;
        npix = which ? 32 : 384000;
        bsz  = which ? 8 : 64;
        depth = which ? 16 : 256;
        @(negedge clk);
        if (which) rst_b = 1'b0;
        else rst_a = 1'b0;
        #1;
        chk("rst_stb", 32'(o_stb), 32'd0);
        chk("rst_adr", o_adr, 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_sof", 32'(o_sof), 32'd0);
        chk("tie_we", 32'(o_we), 32'd0);
        chk("tie_sel", 32'(o_sel), 32'hf);
    endtask

    typedef struct {
        int n;
        bit a;
        bit r;
        bit e_stb;
        int e_adr;
        int e_lvl;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1,  1'b0, 1'b1, 1'b1, 0,    0};
        tbl[1]  = '{64, 1'b1, 1'b0, 1'b0, 256,  64};
        tbl[2]  = '{1,  1'b1, 1'b0, 1'b1, 256,  64};
        tbl[3]  = '{64, 1'b1, 1'b0, 1'b0, 512,  128};
        tbl[4]  = '{1,  1'b1, 1'b0, 1'b1, 512,  128};
        tbl[5]  = '{64, 1'b1, 1'b0, 1'b0, 768,  192};
        tbl[6]  = '{1,  1'b1, 1'b0, 1'b1, 768,  192};
        tbl[7]  = '{64, 1'b1, 1'b0, 1'b0, 1024, 256};
        tbl[8]  = '{5,  1'b1, 1'b0, 1'b0, 1024, 256};
        tbl[9]  = '{64, 1'b1, 1'b1, 1'b0, 1024, 192};
        tbl[10] = '{1,  1'b0, 1'b0, 1'b1, 1024, 192};
        tbl[11] = '{10, 1'b0, 1'b0, 1'b1, 1024, 192};
        tbl[12] = '{63, 1'b1, 1'b0, 1'b1, 1276, 255};
        tbl[13] = '{1,  1'b1, 1'b1, 1'b0, 1280, 255};
        tbl[14] = '{3,  1'b0, 1'b0, 1'b0, 1280, 255};

        // Deterministic burst sequence on the full-size instance.
        do_reset(1'b0);
        for (int i = 0; i < 15; i++) begin
            ack    = tbl[i].a;
            pix_rd = tbl[i].r;
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d_stb", i), 32'(o_stb), 32'(tbl[i].e_stb));
            chk($sformatf("vec%0d_adr", i), o_adr, 32'(tbl[i].e_adr));
            chk($sformatf("vec%0d_level", i), 32'(o_level), 32'(tbl[i].e_lvl));
        end

        // Random ack stalls and pops.
        do_reset(1'b0);
        for (int i = 0; i < 4000; i++) begin
            ack    = 1'($urandom_range(0, 1));
            pix_rd = ($urandom_range(0, 4) != 0);
            step();
        end

        // Asynchronous reset in the middle of a burst.
        do_reset(1'b0);
        ack = 1'b1;
        repeat (21) step();
        chk("pre_rst_level", 32'(o_level), 32'd20);
        #2 rst_a = 1'b1;
        #1;
        chk("async_stb", 32'(o_stb), 32'd0);
        chk("async_cyc", 32'(o_cyc), 32'd0);
        chk("async_empty", 32'(o_empty), 32'd1);
        chk("async_level", 32'(o_level), 32'd0);
        do_reset(1'b0);
        ack    = 1'b1;
        pix_rd = 1'b1;
        repeat (100) step();

        // Tiny frame: address wrap and start-of-frame marking.
        do_reset(1'b1);
        ack    = 1'b1;
        pix_rd = 1'b1;
        repeat (200) step();
        for (int i = 0; i < 1000; i++) begin
            ack    = 1'($urandom_range(0, 1));
            pix_rd = 1'($urandom_range(0, 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
